// File: rtl/agp_mem_pkg.sv
// agp_mem_pkg: shared encodings and helpers for the agp memory-stage controller.
package agp_mem_pkg;

    // Request opcode carried on req_op
    typedef enum logic [2:0] {
        OpNone   = 3'd0,
        OpLoadW  = 3'd1,
        OpLoadB  = 3'd2,
        OpStoreW = 3'd3,
        OpStoreB = 3'd4,
        OpAcc    = 3'd5,
        OpIntr   = 3'd6
    } mem_op_t;

    // Command driven onto the data-memory bus
    typedef enum logic [2:0] {
        CmdNone      = 3'd0,
        CmdSync      = 3'd1,
        CmdRead      = 3'd2,
        CmdWrite     = 3'd3,
        CmdInterrupt = 3'd4
    } mem_cmd_t;

    // Controller FSM states
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StMemWait  = 3'd1,
        StAccWait  = 3'd2,
        StInit     = 3'd3,
        StIntrWait = 3'd4,
        StError    = 3'd5
    } ctrl_state_t;

    localparam mem_cmd_t CMD_NONE = CmdNone;

    // Width of the byte-lane index within a data word
    function automatic int unsigned lane_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/agp_byte_lane.sv
// agp_byte_lane: byte extraction for LOAD_B and strobe/replication for STORE_B.
module agp_byte_lane
    import agp_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [lane_w(DATA_W)-1:0] load_lane,
    input  logic [DATA_W-1:0]         rdata,
    output logic [DATA_W-1:0]         load_data,
    input  logic [lane_w(DATA_W)-1:0] store_lane,
    input  logic [7:0]                store_byte,
    output logic [DATA_W/8-1:0]       store_strb,
    output logic [DATA_W-1:0]         store_data
);

    // Selected byte of the read word, zero-extended; one-hot strobe for the store lane
    always_comb begin
        load_data             = '0;
        load_data[7:0]        = rdata[load_lane*8 +: 8];
        store_strb            = '0;
        store_strb[store_lane] = 1'b1;
    end

    // Store byte is replicated so the strobed lane carries it regardless of position
    assign store_data = {(DATA_W/8){store_byte}};

endmodule

// File: rtl/agp_mem_ctrl.sv
// agp_mem_ctrl: MEM-stage controller sequencing memory, accelerators and interrupts.
// Optional watchdog on the wait states is built when AGP_MEM_TIMEOUT_EN is defined.
module agp_mem_ctrl
    import agp_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NUM_ACC = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [2:0]                req_acc_sel,
    output logic                      resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    input  logic                      mem_start_ready,
    input  logic                      mem_ready,
    input  logic [1:0]                mem_error,
    input  logic [DATA_W-1:0]         data_rdata,
    output logic [2:0]                command,
    output logic [ADDR_W-1:0]         data_addr,
    output logic [DATA_W-1:0]         data_wdata,
    output logic [DATA_W/8-1:0]       data_wstrb,
    output logic [DATA_W-1:0]         acc_arg,
    output logic [NUM_ACC-1:0]        acc_arg_valid,
    input  logic [NUM_ACC*DATA_W-1:0] acc_res,
    input  logic [NUM_ACC-1:0]        acc_res_ready,
    output logic                      interrupt_req,
    input  logic                      interrupt_ack,
    output logic                      fault
);

    localparam int unsigned L = lane_w(DATA_W);

    ctrl_state_t         state_q, state_d;
    mem_cmd_t            cmd_q, cmd_d;
    mem_op_t             op_q, op_d;
    logic [2:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   acc_arg_q, acc_arg_d;
    logic [NUM_ACC-1:0]  acc_vld_q, acc_vld_d;
    logic                intr_q, intr_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                fault_q, fault_d;

    logic                go_err;
    logic                sel_rdy;
    logic [DATA_W-1:0]   sel_res;
    logic [DATA_W-1:0]   ld_byte;
    logic [DATA_W/8-1:0] st_strb;
    logic [DATA_W-1:0]   st_data;

`ifdef AGP_MEM_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 2);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    agp_byte_lane #(
        .DATA_W(DATA_W)
    ) u_byte_lane (
        .load_lane (addr_q[L-1:0]),
        .rdata     (data_rdata),
        .load_data (ld_byte),
        .store_lane(req_addr[L-1:0]),
        .store_byte(req_wdata[7:0]),
        .store_strb(st_strb),
        .store_data(st_data)
    );

    // Result and ready of the accelerator channel latched at acceptance
    always_comb begin
        sel_rdy = 1'b0;
        sel_res = '0;
        for (int unsigned k = 0; k < NUM_ACC; k++) begin
            if (32'(sel_q) == k) begin
                sel_rdy = acc_res_ready[k];
                sel_res = acc_res[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic; mem_error overrides everything outside INIT
    always_comb begin
        state_d      = state_q;
        cmd_d        = CMD_NONE;
        op_d         = op_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        acc_arg_d    = acc_arg_q;
        acc_vld_d    = '0;
        intr_d       = intr_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        fault_d      = fault_q;
        go_err       = 1'b0;

        unique case (state_q)
            StInit: begin
                if (mem_start_ready) begin
                    cmd_d   = CmdSync;
                    op_d    = OpNone;  // OpNone in MEM_WAIT marks the silent SYNC
                    state_d = StMemWait;
                end
            end
            StIdle: begin
                if (req_valid && req_ready) begin
                    sel_d = req_acc_sel;
                    op_d  = OpNone;
                    case (req_op)
                        OpLoadW, OpLoadB: begin
                            op_d    = (req_op == OpLoadW) ? OpLoadW : OpLoadB;
                            cmd_d   = CmdRead;
                            addr_d  = req_addr;
                            state_d = StMemWait;
                        end
                        OpStoreW: begin
                            op_d    = OpStoreW;
                            cmd_d   = CmdWrite;
                            addr_d  = req_addr;
                            wdata_d = req_wdata;
                            wstrb_d = '1;
                            state_d = StMemWait;
                        end
                        OpStoreB: begin
                            op_d    = OpStoreB;
                            cmd_d   = CmdWrite;
                            addr_d  = req_addr;
                            wdata_d = st_data;
                            wstrb_d = st_strb;
                            state_d = StMemWait;
                        end
                        OpAcc: begin
                            op_d      = OpAcc;
                            acc_arg_d = req_wdata;
                            for (int unsigned k = 0; k < NUM_ACC; k++) begin
                                acc_vld_d[k] = (32'(req_acc_sel) == k);
                            end
                            state_d   = StAccWait;
                        end
                        OpIntr: begin
                            op_d    = OpIntr;
                            cmd_d   = CmdInterrupt;
                            addr_d  = '0;
                            state_d = StMemWait;
                        end
                        default: resp_valid_d = 1'b1;
                    endcase
                end
            end
            StMemWait: begin
                if (mem_ready && cmd_q == CMD_NONE) begin
                    if (op_q == OpIntr) begin
                        intr_d  = 1'b1;
                        state_d = StIntrWait;
                    end else begin
                        state_d      = StIdle;
                        resp_valid_d = (op_q != OpNone);
                        if (op_q == OpLoadW) resp_data_d = data_rdata;
                        if (op_q == OpLoadB) resp_data_d = ld_byte;
                    end
                end
            end
            StAccWait: begin
                // acc_vld_q nonzero marks the pulse cycle, whose ready is ignored
                if (acc_vld_q == '0) begin
                    if (32'(sel_q) >= NUM_ACC) begin
                        resp_data_d  = '0;
                        resp_valid_d = 1'b1;
                        state_d      = StIdle;
                    end else if (sel_rdy) begin
                        resp_data_d  = sel_res;
                        resp_valid_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
            end
            StIntrWait: begin
                if (interrupt_ack) begin
                    intr_d       = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            StError: state_d = StError;
            default: go_err = 1'b1;
        endcase

`ifdef AGP_MEM_TIMEOUT_EN
        wd_d = '0;
        if (state_d == state_q && state_q inside {StMemWait, StAccWait, StIntrWait}) begin
            wd_d = wd_q + 1'b1;
            if (TIMEOUT != 0 && 32'(wd_q) + 32'd1 >= TIMEOUT) go_err = 1'b1;
        end
`endif

        if (state_q != StInit && mem_error != 2'd0) go_err = 1'b1;

        if (go_err) begin
            state_d      = StError;
            cmd_d        = CMD_NONE;
            acc_vld_d    = '0;
            intr_d       = 1'b0;
            resp_valid_d = 1'b0;
            fault_d      = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StInit;
            cmd_q        <= CMD_NONE;
            op_q         <= OpNone;
            sel_q        <= '0;
            addr_q       <= '1;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            acc_arg_q    <= '0;
            acc_vld_q    <= '0;
            intr_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            op_q         <= op_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            acc_arg_q    <= acc_arg_d;
            acc_vld_q    <= acc_vld_d;
            intr_q       <= intr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            fault_q      <= fault_d;
        end
    end

`ifdef AGP_MEM_TIMEOUT_EN
    // Wait-state watchdog counter
    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`endif

    assign req_ready     = (state_q == StIdle) && mem_ready;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign command       = cmd_q;
    assign data_addr     = addr_q;
    assign data_wdata    = wdata_q;
    assign data_wstrb    = wstrb_q;
    assign acc_arg       = acc_arg_q;
    assign acc_arg_valid = acc_vld_q;
    assign interrupt_req = intr_q;
    assign fault         = fault_q;

endmodule

// File: doc/agp_mem_ctrl.md
Name: agp_mem_ctrl

Overview:
- Parametrised memory-stage controller for the agp pipeline: accepts one MEM-stage request at a time, sequences the data-memory command bus, N accelerator channels and the interrupt handshake, and stalls the pipeline until completion.
- Successor to the single-accelerator, fixed 32-bit in-core state machine.
- Adds: configurable data width, multiple accelerator channels, sticky fault reporting, and an optional watchdog.

Parameters:
- DATA_W, 32: data bus width. Multiple of 8, at least 16.
- ADDR_W, 32: address width.
- NUM_ACC, 2: number of accelerator channels, 1..8.
- TIMEOUT, 255: watchdog limit in cycles. Used only with AGP_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  3  0 NONE, 1 LOAD_W, 2 LOAD_B, 3 STORE_W, 4 STORE_B, 5 ACC, 6 INTR.
- req_addr  in  ADDR_W  load/store address.
- req_wdata  in  DATA_W  store data or accelerator argument.
- req_acc_sel  in  3  accelerator channel index.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  DATA_W  load or accelerator result.
- mem_start_ready  in  1  memory initialised.
- mem_ready  in  1  memory idle.
- mem_error  in  2  nonzero means memory fault.
- data_rdata  in  DATA_W  read data.
- command  out  3  0 NONE, 1 SYNC, 2 READ, 3 WRITE, 4 INTERRUPT.
- data_addr  out  ADDR_W  memory address.
- data_wdata  out  DATA_W  write data.
- data_wstrb  out  DATA_W/8  byte strobes.
- acc_arg  out  DATA_W  accelerator argument, shared by all channels.
- acc_arg_valid  out  NUM_ACC  per-channel argument pulse.
- acc_res  in  NUM_ACC*DATA_W  packed results; channel k occupies bits [k*DATA_W +: DATA_W].
- acc_res_ready  in  NUM_ACC  per-channel result valid.
- interrupt_req  out  1  interrupt request.
- interrupt_ack  in  1  interrupt acknowledge.
- fault  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state INIT; command 0; data_addr all ones; data_wdata 0; data_wstrb 0.
  - acc_arg 0; acc_arg_valid 0; interrupt_req 0; resp_valid 0; resp_data 0; fault 0.
  - Watchdog counter 0.
- Reset mid-operation: the in-flight request is dropped with no resp_valid, and all outputs return to their reset values.
- State encoding: IDLE=0, MEM_WAIT=1, ACC_WAIT=2, INIT=3, INTR_WAIT=4, ERROR=5.
- INIT: when mem_start_ready=1, drive command=1 (SYNC) and go to MEM_WAIT. The SYNC op completes without resp_valid.
- req_ready = 1 only when state==IDLE and mem_ready==1. A request is accepted when req_valid && req_ready.
- Accepting an op of NONE: resp_valid pulses the next cycle and the state stays IDLE.
- LOAD_W / LOAD_B:
  - command=2, data_addr=req_addr; go to MEM_WAIT.
- STORE_W:
  - command=3, data_addr=req_addr, data_wdata=req_wdata, data_wstrb all ones; go to MEM_WAIT.
- STORE_B:
  - lane = req_addr[L-1:0], where L = log2(DATA_W/8).
  - data_wstrb = 1<<lane.
  - data_wdata = req_wdata[7:0] replicated into every byte lane.
  - command=3; go to MEM_WAIT.
- command is held for exactly one cycle and then driven 0.
- MEM_WAIT completion:
  - Completes on the first cycle with mem_ready==1 && command==0, so the earliest completion is 2 cycles after acceptance.
  - On completion go to IDLE and pulse resp_valid.
  - resp_data for LOAD_W: data_rdata.
  - resp_data for LOAD_B: the byte at lane addr[L-1:0] of data_rdata, zero-extended.
- ACC:
  - acc_arg=req_wdata; acc_arg_valid[req_acc_sel] pulses for one cycle; go to ACC_WAIT.
  - Completion: the first cycle after the pulse in which acc_res_ready[sel]==1. Then resp_data = channel sel of acc_res, resp_valid pulses, and the state returns to IDLE.
  - acc_res_ready during the pulse cycle is ignored.
  - req_acc_sel >= NUM_ACC: no pulse; complete the next cycle with resp_data 0.
- INTR:
  - command=4, data_addr=0; go to MEM_WAIT with an interrupt flag set.
  - On memory completion, set interrupt_req=1 and go to INTR_WAIT instead of IDLE.
  - INTR_WAIT: on interrupt_ack, clear interrupt_req, pulse resp_valid, go to IDLE.
  - interrupt_ack in any other state is ignored.
- Error handling:
  - mem_error != 0 in any state except INIT moves the FSM to ERROR next cycle and takes priority over every other transition in that cycle.
  - ERROR: fault=1, req_ready=0, command=0, no resp_valid. Only rst exits ERROR.

Optional Feature:
- Macro AGP_MEM_TIMEOUT_EN.
- Enabled: a counter increments each cycle in MEM_WAIT, ACC_WAIT or INTR_WAIT and clears on any state change. Reaching TIMEOUT moves the FSM to ERROR with fault=1. TIMEOUT=0 disables the check.
- Disabled: no counter is built; the wait states wait indefinitely.

Decomposition:
- Package agp_mem_pkg holds:
  - typedef mem_op_t (req_op encoding);
  - typedef mem_cmd_t (command encoding);
  - typedef ctrl_state_t (state encoding);
  - constant CMD_NONE, plus the lane-index width function.
- One sub-module: agp_byte_lane, combinational. It does byte extraction and zero-extension for loads, and strobe/replication for byte stores.

Test Plan:
- Reset release with mem_start_ready=1 at cycle 3 → command=1 at cycle 4; req_ready=1 once mem_ready=1.
- LOAD_B, addr 0x1002, data_rdata 0xAABBCCDD, DATA_W=32 → command=2 for one cycle, resp_data=0x000000BB, one resp_valid pulse.
- STORE_B, addr 0x2003, wdata 0x5A → data_wstrb=4'b1000, data_wdata=0x5A5A5A5A.
- ACC, sel=1, arg 0x00030004; acc_res_ready[1] asserted 3 cycles later with result 0x7 → only acc_arg_valid[1] pulses; resp_data=0x7; req_ready low throughout.
- INTR → command=4, data_addr=0, then interrupt_req=1; interrupt_ack 5 cycles later → interrupt_req=0 and resp_valid pulse.
- mem_error=2'd1 during MEM_WAIT → fault=1 and req_ready=0 until rst. With AGP_MEM_TIMEOUT_EN and TIMEOUT=8 and acc_res_ready never asserted → fault=1 on the 8th wait cycle.
